// File: rtl/anubis_theta_iter.sv
// rtl/anubis_theta_iter.sv - iterative ANUBIS theta layer, ROWS_PER_CYCLE rows per clock
// Optional fused round-key XOR: define ANUBIS_THETA_KEYADD_EN.
module anubis_theta_iter #(
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] idat,
`ifdef ANUBIS_THETA_KEYADD_EN
  input  logic [127:0] key,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] odat,
  output logic         busy
);

  localparam int NUM_STEPS = 4 / ROWS_PER_CYCLE;

  if (!(ROWS_PER_CYCLE == 1 || ROWS_PER_CYCLE == 2 || ROWS_PER_CYCLE == 4)) begin : g_bad_rpc
    $error("anubis_theta_iter: ROWS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t       state_q;
  logic [1:0]   cnt_q;
  logic [127:0] in_q;
  logic [127:0] out_q;
  logic         out_valid_q;
  logic         busy_q;
  logic [127:0] key_mix;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1D : 8'h00);
  endfunction

  // One row of the involutional MDS multiply with h = {01,02,04,06}.
  function automatic logic [31:0] theta_row(input logic [31:0] r);
    logic [7:0] a [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m6 [4];
    for (int c = 0; c < 4; c++) begin
      a[c]  = r[8*c +: 8];
      m2[c] = xtime(a[c]);
      m4[c] = xtime(m2[c]);
      m6[c] = m4[c] ^ m2[c];
    end
    return {a[3] ^ m2[2] ^ m4[1] ^ m6[0],
            m2[3] ^ a[2] ^ m6[1] ^ m4[0],
            m4[3] ^ m6[2] ^ a[1] ^ m2[0],
            m6[3] ^ m4[2] ^ m2[1] ^ a[0]};
  endfunction

  // Bit offset of lane r of the rows handled in step cnt.
  function automatic logic [6:0] row_lsb(input logic [1:0] cnt, input int r);
    int idx;
    idx = int'(cnt) * ROWS_PER_CYCLE + r;
    return 7'(idx * 32);
  endfunction

`ifdef ANUBIS_THETA_KEYADD_EN
  logic [127:0] key_q;
  assign key_mix = key_q;
`else
  assign key_mix = '0;
`endif

  // Ready while idle, or while the held result is being taken this cycle.
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign odat      = out_q;

  // Control FSM plus row-sliced datapath; reset discards any partial block.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      in_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ANUBIS_THETA_KEYADD_EN
      key_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            in_q    <= idat;
`ifdef ANUBIS_THETA_KEYADD_EN
            key_q   <= key;
`endif
            cnt_q   <= 2'd0;
            busy_q  <= 1'b1;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          for (int r = 0; r < ROWS_PER_CYCLE; r++) begin
            out_q[row_lsb(cnt_q, r) +: 32] <= theta_row(in_q[row_lsb(cnt_q, r) +: 32])
                                              ^ key_mix[row_lsb(cnt_q, r) +: 32];
          end
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'(NUM_STEPS - 1)) begin
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              in_q    <= idat;
`ifdef ANUBIS_THETA_KEYADD_EN
              key_q   <= key;
`endif
              cnt_q   <= 2'd0;
              busy_q  <= 1'b1;
              state_q <= S_BUSY;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
